// File: rtl/cjb_mc_sequencer_v_pkg.sv
// Shared types and constants for the multi-cycle control sequencer:
// opcode classes, machine-cycle indices, FSM states and fault codes.
package cjb_mc_sequencer_v_pkg;

  typedef enum logic [2:0] {
    OP_ALU    = 3'd0,
    OP_LOAD   = 3'd1,
    OP_STORE  = 3'd2,
    OP_BRANCH = 3'd3,
    OP_JUMP   = 3'd4,
    OP_HALT   = 3'd5,
    OP_ILL6   = 3'd6,
    OP_ILL7   = 3'd7
  } opclass_t;

  localparam int MC_FETCH = 0;
  localparam int MC_DEC   = 1;
  localparam int MC_EXE   = 2;
  localparam int MC_MEM   = 3;
  localparam int MC_WB    = 4;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RUN    = 2'd1,
    ST_HALTED = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    ERR_NONE    = 2'd0,
    ERR_TIMEOUT = 2'd1,
    ERR_ILLEGAL = 2'd2
  } err_t;

  // Classes that touch data memory in MC3.
  function automatic logic is_mem_class(opclass_t c);
    return (c == OP_LOAD) || (c == OP_STORE);
  endfunction

  function automatic logic is_illegal(opclass_t c);
    return (c == OP_ILL6) || (c == OP_ILL7);
  endfunction

endpackage

// File: rtl/cjb_mc_sequencer_v_if.sv
// Control/status bundle between the core and its machine-cycle sequencer.
interface cjb_mc_sequencer_v_if #(
  parameter int MC_W = 3
);
  logic            start;
  logic [2:0]      opclass;
  logic            mem_ready;
  logic [MC_W-1:0] mc;
  logic [4:0]      mc_oh;
  logic            stall;
  logic            instr_done;
  logic            busy;
  logic            halted;
  logic [1:0]      err;

  modport master (
    output start, opclass, mem_ready,
    input  mc, mc_oh, stall, instr_done, busy, halted, err
  );

  modport slave (
    input  start, opclass, mem_ready,
    output mc, mc_oh, stall, instr_done, busy, halted, err
  );
endinterface

// File: rtl/cjb_mc_sequencer_v_cntup.sv
// Generic n-bit up-counter with synchronous clear, parallel load and count enable.
module cjb_nbit_cntup_v #(
  parameter int n = 3
) (
  input  logic         clock,
  input  logic         cnt_reset,
  input  logic         ld,
  input  logic [n-1:0] d,
  input  logic         cntup,
  output logic [n-1:0] q
);

  logic [n-1:0] q_q;

  // NOTE: reset is sampled on the clock edge only (synchronous), so it sits
  // inside the edge-triggered block rather than in the sensitivity list.
  always_ff @(posedge clock) begin
    if (cnt_reset)  q_q <= '0;
    else if (ld)    q_q <= d;
    else if (cntup) q_q <= q_q + 1'b1;
  end

  assign q = q_q;

endmodule

// File: rtl/cjb_mc_sequencer_v.sv
// Machine-cycle sequencer: steps MC0..MC4 per instruction, ends early by
// opcode class, holds on memory stalls with a timeout, parks in HALTED.
module cjb_mc_sequencer_v
  import cjb_mc_sequencer_v_pkg::*;
#(
  parameter int MC_W    = 3,
  parameter int TIMEOUT = 15
) (
  input logic                clock,
  input logic                reset,
  cjb_mc_sequencer_v_if.slave bus
);

  state_t          state_q, state_d;
  logic [7:0]      wait_q, wait_d;
  opclass_t        class_q, class_d;
  err_t            err_q, err_d;
  logic            cnt_ld, cnt_up;
  logic [MC_W-1:0] mc_q;

  opclass_t opc_in;
  logic     busy, mem_cycle, stall, at_dec, last_cycle, instr_done;

  cjb_nbit_cntup_v #(.n(MC_W)) u_mc_cnt (
    .clock     (clock),
    .cnt_reset (reset),
    .ld        (cnt_ld),
    .d         ('0),
    .cntup     (cnt_up),
    .q         (mc_q)
  );

  assign opc_in = opclass_t'(bus.opclass);
  assign busy   = (state_q == ST_RUN);
  assign at_dec = (mc_q == MC_W'(MC_DEC));

  // JUMP/HALT/illegal are decided in MC1 before class_q exists, so they use
  // the live opclass; later cycles rely only on the latched class.
  always_comb begin
    mem_cycle  = (mc_q == MC_W'(MC_FETCH)) ||
                 ((mc_q == MC_W'(MC_MEM)) && is_mem_class(class_q));
    last_cycle = 1'b0;
    if (at_dec)
      last_cycle = (opc_in == OP_JUMP) || (opc_in == OP_HALT) || is_illegal(opc_in);
    else if (mc_q == MC_W'(MC_EXE))
      last_cycle = (class_q == OP_ALU) || (class_q == OP_BRANCH);
    else if (mc_q == MC_W'(MC_MEM))
      last_cycle = (class_q == OP_STORE);
    else if (mc_q == MC_W'(MC_WB))
      last_cycle = (class_q == OP_LOAD);
  end

  assign stall      = busy && mem_cycle && !bus.mem_ready;
  assign instr_done = busy && !stall && last_cycle;

  // NOTE: every variable gets a default before the case so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d = state_q;
    wait_d  = wait_q;
    class_d = class_q;
    err_d   = err_q;
    cnt_ld  = 1'b0;
    cnt_up  = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          state_d = ST_RUN;
          cnt_ld  = 1'b1;
        end
      end
      ST_RUN: begin
        if (stall) begin
          wait_d = wait_q + 8'd1;
          if (wait_q == 8'(TIMEOUT - 1)) begin
            err_d   = ERR_TIMEOUT;
            state_d = ST_HALTED;
            cnt_ld  = 1'b1;
          end
        end else if (last_cycle) begin
          wait_d = '0;
          cnt_ld = 1'b1;
          if (at_dec && opc_in == OP_HALT) begin
            state_d = ST_HALTED;
          end else if (at_dec && is_illegal(opc_in)) begin
            err_d   = ERR_ILLEGAL;
            state_d = ST_HALTED;
          end
        end else begin
          wait_d = '0;
          cnt_up = 1'b1;
          if (at_dec) class_d = opc_in;
        end
      end
      ST_HALTED: begin
        if (bus.start) begin
          err_d   = ERR_NONE;
          wait_d  = '0;
          state_d = ST_RUN;
          cnt_ld  = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers
  // update together from values sampled before the edge.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= ST_IDLE;
      wait_q  <= '0;
      class_q <= OP_ALU;
      err_q   <= ERR_NONE;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
      class_q <= class_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    for (int i = 0; i < 5; i++) bus.mc_oh[i] = busy && (mc_q == MC_W'(i));
  end

  assign bus.mc         = mc_q;
  assign bus.stall      = stall;
  assign bus.instr_done = instr_done;
  assign bus.busy       = busy;
  assign bus.halted     = (state_q == ST_HALTED);
  assign bus.err        = err_q;

endmodule

// File: tb/tb_cjb_mc_sequencer_v.sv
// Directed-vector bench for cjb_mc_sequencer_v with a per-cycle scoreboard.
module tb_cjb_mc_sequencer_v;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  cjb_mc_sequencer_v_if #(.MC_W(3)) bus ();

  cjb_mc_sequencer_v #(.MC_W(3), .TIMEOUT(4)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct packed {
    logic       rst;
    logic       st;
    logic [2:0] opc;
    logic       mr;
    logic [2:0] mc;
    logic       stall;
    logic       done;
    logic       busy;
    logic       halted;
    logic [1:0] err;
  } vec_t;

  // Expected snapshot order: mc, mc_oh, stall, instr_done, busy, halted, err.
  typedef struct {
    int          idx;
    logic [13:0] exp;
  } sb_t;

  vec_t vecs[$];
  sb_t  sb[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  task automatic check(input string name, input logic [13:0] act, input logic [13:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %b expected %b (mc,oh,stall,done,busy,halted,err)", name, act, exp);
  endtask

  task automatic v(input logic rst, input logic st, input logic [2:0] opc, input logic mr,
                   input logic [2:0] mc, input logic stl, input logic dn,
                   input logic bs, input logic hl, input logic [1:0] er);
    vecs.push_back('{rst, st, opc, mr, mc, stl, dn, bs, hl, er});
  endtask

  function automatic logic [13:0] pack_exp(input vec_t x);
    logic [4:0] oh;
    oh = '0;
    if (x.busy) oh[x.mc] = 1'b1;
    return {x.mc, oh, x.stall, x.done, x.busy, x.halted, x.err};
  endfunction

  initial begin
    //  rst st opc mr | mc stl dn bs hl err
    // Reset state, start, then ALU: 0,1,2 with done at MC2
    v(0,0,0,1, 0,0,0,0,0,0);
    v(0,1,0,1, 0,0,0,0,0,0);
    v(0,0,0,1, 0,0,0,1,0,0);
    v(0,0,0,1, 1,0,0,1,0,0);
    v(0,0,0,1, 2,0,1,1,0,0);
    // LOAD (5 cycles) then STORE (4 cycles)
    v(0,0,1,1, 0,0,0,1,0,0);
    v(0,0,1,1, 1,0,0,1,0,0);
    v(0,0,1,1, 2,0,0,1,0,0);
    v(0,0,1,1, 3,0,0,1,0,0);
    v(0,0,1,1, 4,0,1,1,0,0);
    v(0,0,2,1, 0,0,0,1,0,0);
    v(0,0,2,1, 1,0,0,1,0,0);
    v(0,0,2,1, 2,0,0,1,0,0);
    v(0,0,2,1, 3,0,1,1,0,0);
    // LOAD stalled 3 cycles (TIMEOUT-1) in MC3; opclass changes ignored after MC1
    v(0,0,1,1, 0,0,0,1,0,0);
    v(0,0,1,1, 1,0,0,1,0,0);
    v(0,0,1,0, 2,0,0,1,0,0);
    v(0,0,7,0, 3,1,0,1,0,0);
    v(0,0,7,0, 3,1,0,1,0,0);
    v(0,0,7,0, 3,1,0,1,0,0);
    v(0,0,7,1, 3,0,0,1,0,0);
    v(0,0,7,1, 4,0,1,1,0,0);
    // JUMP then HALT, both end at MC1
    v(0,0,4,1, 0,0,0,1,0,0);
    v(0,0,4,1, 1,0,1,1,0,0);
    v(0,0,5,1, 0,0,0,1,0,0);
    v(0,0,5,1, 1,0,1,1,0,0);
    v(0,0,5,1, 0,0,0,0,1,0);
    v(0,0,0,0, 0,0,0,0,1,0);
    // Resume, illegal opclass 6 -> err=2
    v(0,1,6,1, 0,0,0,0,1,0);
    v(0,0,6,1, 0,0,0,1,0,0);
    v(0,0,6,1, 1,0,1,1,0,0);
    v(0,0,6,1, 0,0,0,0,1,2);
    // Resume clears err; fetch stall of 4 cycles times out
    v(0,1,0,0, 0,0,0,0,1,2);
    v(0,0,0,0, 0,1,0,1,0,0);
    v(0,0,0,0, 0,1,0,1,0,0);
    v(0,0,0,0, 0,1,0,1,0,0);
    v(0,0,0,0, 0,1,0,1,0,0);
    v(0,0,0,0, 0,0,0,0,1,1);
    // Resume (start in RUN ignored), STORE, reset+start in MC3
    v(0,1,2,1, 0,0,0,0,1,1);
    v(0,1,2,1, 0,0,0,1,0,0);
    v(0,0,2,1, 1,0,0,1,0,0);
    v(0,0,2,1, 2,0,0,1,0,0);
    v(1,1,2,0, 3,1,0,1,0,0);
    v(0,0,2,0, 0,0,0,0,0,0);
    v(0,0,2,0, 0,0,0,0,0,0);

    bus.start     = 1'b0;
    bus.opclass   = 3'd0;
    bus.mem_ready = 1'b1;
    reset         = 1'b1;
    repeat (2) @(posedge clock);
    foreach (vecs[k]) begin
      #1;
      reset         = vecs[k].rst;
      bus.start     = vecs[k].st;
      bus.opclass   = vecs[k].opc;
      bus.mem_ready = vecs[k].mr;
      sb.push_back('{k, pack_exp(vecs[k])});
      @(posedge clock);
    end
    repeat (2) @(posedge clock);
    check("scoreboard drained", {13'd0, sb.size() == 0}, 14'd1);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  // Monitor: every cycle the DUT presents a snapshot mid-cycle.
  initial begin
    sb_t e;
    forever begin
      @(negedge clock);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        check($sformatf("cycle %0d", e.idx),
              {bus.mc, bus.mc_oh, bus.stall, bus.instr_done, bus.busy, bus.halted, bus.err},
              e.exp);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
